adc_seqctrl: RTL and testbench

Conversion sequencer and bit collector for the SAR `adc` block. On each accepted start it drives the four phase strobes (`seq_init`, `seq_samp`, `seq_comp`, `seq_update`) in the fixed order one conversion requires. It captures the serial `comp_out` decision after every comparison. It presents the assembled Madc-bit raw code to the readout through a one-deep valid/ready buffer. Redundancy decoding to N bits happens further downstream and is out of scope.

---
 rtl/adc_pkg.sv | 15 +
 rtl/adc_bitcap.sv | 52 +++++
 rtl/adc_seqctrl.sv | 117 +++++++++++
 tb/tb_adc_seqctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: shared state encoding and default sizing for adc and adc_seqctrl
package adc_pkg;

    localparam int ADC_MADC     = 17;
    localparam int ADC_SAMP_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SAMP,
        ST_COMP,
        ST_SLOT
    } adc_seq_state_t;

endpackage

// File: rtl/adc_bitcap.sv
// adc_bitcap: shadow bit capture, result register and one-deep valid/ready/overrun buffer
module adc_bitcap
    import adc_pkg::*;
#(
    parameter int Madc = ADC_MADC,
    parameter int BW   = $clog2(Madc)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cap,
    input  logic            last,
    input  logic [BW-1:0]   idx,
    input  logic            comp_out,
    input  logic            result_ready,
    input  logic            ovr_clr,
    output logic [Madc-1:0] result,
    output logic            result_valid,
    output logic            overrun,
    output logic            load
);

    logic [Madc-1:0] shadow;
    logic [Madc-1:0] shadow_nxt;
    logic [BW-1:0]   pos;

    assign pos  = BW'(Madc - 1) - idx;
    assign load = cap & last;

    // shadow with the current slot's decision merged in, so the final bit reaches result on the same edge
    always_comb begin
        shadow_nxt      = shadow;
        shadow_nxt[pos] = comp_out;
    end

    // capture, result load, valid handshake and sticky overrun (set beats clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow       <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (cap)
                shadow <= shadow_nxt;
            if (load)
                result <= shadow_nxt;
            result_valid <= load | (result_valid & ~result_ready);
            overrun      <= (load & result_valid & ~result_ready) | (overrun & ~ovr_clr);
        end
    end

endmodule

// File: rtl/adc_seqctrl.sv
// adc_seqctrl: SAR conversion sequencer; optional conv_cnt port via ADC_SEQCTRL_CONVCNT_EN
module adc_seqctrl
    import adc_pkg::*;
#(
    parameter int Madc     = ADC_MADC,
    parameter int SAMP_CYC = ADC_SAMP_CYC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            seq_init,
    output logic            seq_samp,
    output logic            seq_comp,
    output logic            seq_update,
    input  logic            comp_out,
    output logic [Madc-1:0] result,
    output logic            result_valid,
    input  logic            result_ready,
    output logic            overrun,
    input  logic            ovr_clr
`ifdef ADC_SEQCTRL_CONVCNT_EN
    ,
    output logic [15:0]     conv_cnt
`endif
);

    localparam int BW = $clog2(Madc);
    localparam int SW = $clog2(SAMP_CYC + 1);

    adc_seq_state_t state;
    logic [BW-1:0]  bit_cnt;
    logic [SW-1:0]  samp_cnt;
    logic           last;
    logic           load;

    assign last = (bit_cnt == BW'(Madc - 1));

    // sequencer FSM; strobes are registered alongside the state they belong to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            samp_cnt   <= '0;
            busy       <= 1'b0;
            seq_init   <= 1'b0;
            seq_samp   <= 1'b0;
            seq_comp   <= 1'b0;
            seq_update <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: if (start) begin
                    state    <= ST_INIT;
                    busy     <= 1'b1;
                    seq_init <= 1'b1;
                end
                ST_INIT: begin
                    state    <= ST_SAMP;
                    samp_cnt <= '0;
                    seq_init <= 1'b0;
                    seq_samp <= 1'b1;
                end
                ST_SAMP: if (samp_cnt == SW'(SAMP_CYC - 1)) begin
                    state    <= ST_COMP;
                    bit_cnt  <= '0;
                    seq_samp <= 1'b0;
                    seq_comp <= 1'b1;
                end else begin
                    samp_cnt <= samp_cnt + 1'b1;
                end
                ST_COMP: begin
                    state      <= ST_SLOT;
                    seq_comp   <= 1'b0;
                    seq_update <= ~last;
                end
                ST_SLOT: begin
                    seq_update <= 1'b0;
                    if (last) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state    <= ST_COMP;
                        bit_cnt  <= bit_cnt + 1'b1;
                        seq_comp <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    adc_bitcap #(.Madc(Madc), .BW(BW)) u_bitcap (
        .clk          (clk),
        .rst          (rst),
        .cap          (state == ST_SLOT),
        .last         (last),
        .idx          (bit_cnt),
        .comp_out     (comp_out),
        .result_ready (result_ready),
        .ovr_clr      (ovr_clr),
        .result       (result),
        .result_valid (result_valid),
        .overrun      (overrun),
        .load         (load)
    );

`ifdef ADC_SEQCTRL_CONVCNT_EN
    // completed-conversion counter, wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            conv_cnt <= '0;
        else if (load)
            conv_cnt <= conv_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_adc_seqctrl.sv
// tb_adc_seqctrl: randomized directed bench for adc_seqctrl against a transaction-level model
module tb_adc_seqctrl;
    import adc_pkg::*;

    localparam int M  = ADC_MADC;
    localparam int SC = ADC_SAMP_CYC;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         busy, seq_init, seq_samp, seq_comp, seq_update;
    logic         comp_out = 1'b0;
    logic [M-1:0] result;
    logic         result_valid;
    logic         result_ready = 1'b0;
    logic         overrun;
    logic         ovr_clr = 1'b0;
`ifdef ADC_SEQCTRL_CONVCNT_EN
    logic [15:0]  conv_cnt;
`endif

    adc_seqctrl #(.Madc(M), .SAMP_CYC(SC)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .seq_init     (seq_init),
        .seq_samp     (seq_samp),
        .seq_comp     (seq_comp),
        .seq_update   (seq_update),
        .comp_out     (comp_out),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overrun      (overrun),
        .ovr_clr      (ovr_clr)
`ifdef ADC_SEQCTRL_CONVCNT_EN
        ,
        .conv_cnt     (conv_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // transaction-level model of the readout buffer
    logic [M-1:0] m_result = '0;
    logic         m_valid  = 1'b0;
    logic         m_ovr    = 1'b0;
    logic [15:0]  m_cnt    = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_buf(input string tag);
        chk({tag, ":result"}, 32'(result), 32'(m_result));
        chk({tag, ":valid"}, 32'(result_valid), 32'(m_valid));
        chk({tag, ":overrun"}, 32'(overrun), 32'(m_ovr));
`ifdef ADC_SEQCTRL_CONVCNT_EN
        chk({tag, ":conv_cnt"}, 32'(conv_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ":strobes_busy"}, 32'({busy, seq_init, seq_samp, seq_comp, seq_update}), 32'd0);
    endtask

    // one full conversion feeding code MSB first; rdy is result_ready in the final slot cycle
    task automatic conv(input logic [M-1:0] code, input logic rdy, input bit extra_start);
        int cyc = 0, comps = 0, upds = 0, inits = 0, samps = 0, run = 0, maxrun = 0, overlap = 0;
        bit final_slot = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("init_latency", 32'({busy, seq_init}), 32'h3);
        while (busy && cyc < 100) begin
            cyc++;
            if (int'(seq_init) + int'(seq_samp) + int'(seq_comp) + int'(seq_update) > 1) overlap++;
            inits += int'(seq_init);
            samps += int'(seq_samp);
            upds  += int'(seq_update);
            run = seq_samp ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            result_ready = final_slot ? rdy : 1'b0;
            final_slot = 0;
            if (seq_comp) begin
                if (comps < M) comp_out = code[M-1-comps];
                comps++;
                final_slot = (comps == M);
            end
            start = extra_start && (cyc == 5 || cyc == 20);
            @(negedge clk);
        end
        start = 1'b0;
        result_ready = 1'b0;
        if (m_valid && !rdy) m_ovr = 1'b1;
        m_valid  = 1'b1;
        m_result = code;
        m_cnt    = m_cnt + 16'd1;
        chk("busy_cycles", 32'(cyc), 32'(1 + SC + 2 * M));
        chk("init_pulses", 32'(inits), 32'd1);
        chk("samp_cycles", 32'(samps), 32'(SC));
        chk("samp_run", 32'(maxrun), 32'(SC));
        chk("comp_pulses", 32'(comps), 32'(M));
        chk("update_pulses", 32'(upds), 32'(M - 1));
        chk("strobe_overlap", 32'(overlap), 32'd0);
        check_buf("conv");
        repeat (3) @(negedge clk);
        check_idle("no_restart");
    endtask

    task automatic accept();
        @(negedge clk) result_ready = 1'b1;
        @(negedge clk) result_ready = 1'b0;
        m_valid = 1'b0;
        check_buf("accept");
    endtask

    task automatic clear_ovr();
        @(negedge clk) ovr_clr = 1'b1;
        @(negedge clk) ovr_clr = 1'b0;
        m_ovr = 1'b0;
        check_buf("ovr_clr");
    endtask

    // start a conversion and pull reset during comparison 8
    task automatic abort_conv(input logic [M-1:0] code);
        int cyc = 0, comps = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (comps < 8 && cyc < 100) begin
            cyc++;
            if (seq_comp) begin
                comp_out = code[M-1-comps];
                comps++;
            end
            if (comps < 8) @(negedge clk);
        end
        chk("abort_reached", 32'(comps), 32'd8);
        rst = 1'b1;
        #1;
        m_result = '0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
        m_cnt    = '0;
        check_idle("abort");
        check_buf("abort");
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        logic [M-1:0] c;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check_buf("reset");
        rst = 1'b0;
        conv(17'h15555, 1'b0, 1'b0);
        chk("alt_code", 32'(result), 32'h15555);
        accept();
        conv(17'h1FFFF, 1'b0, 1'b0);
        conv(17'h00000, 1'b0, 1'b0);
        chk("overrun_code", 32'({overrun, result}), 32'h20000);
        clear_ovr();
        accept();
        conv(M'($urandom), 1'b0, 1'b0);
        c = M'($urandom);
        conv(c, 1'b1, 1'b0);
        chk("simul_load", 32'({overrun, result_valid, result}), 32'({2'b01, c}));
        accept();
        abort_conv(M'($urandom));
        conv(M'($urandom), 1'b0, 1'b0);
        conv(M'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            conv(M'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) accept();
            if ($urandom_range(0, 2) == 0) clear_ovr();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
